// File: rtl/sys_id_multi.sv
// System ID block: fixed ID registers, scratch register and NUM_ROMS read-only ROM windows
// behind an AXI4-Lite slave. Define SYSID_CHECKSUM_EN to build the ROM checksum scan engine.
module sys_id_multi #(
  parameter int ID            = 0,
  parameter int NUM_ROMS      = 2,
  parameter int ROM_WIDTH     = 32,
  parameter int ROM_ADDR_BITS = 6,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic                          s_axi_awvalid,
  input  logic [15:0]                   s_axi_awaddr,
  input  logic [2:0]                    s_axi_awprot,
  output logic                          s_axi_awready,
  input  logic                          s_axi_wvalid,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  output logic                          s_axi_wready,
  output logic                          s_axi_bvalid,
  output logic [1:0]                    s_axi_bresp,
  input  logic                          s_axi_bready,
  input  logic                          s_axi_arvalid,
  input  logic [15:0]                   s_axi_araddr,
  input  logic [2:0]                    s_axi_arprot,
  output logic                          s_axi_arready,
  output logic                          s_axi_rvalid,
  output logic [31:0]                   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  input  logic                          s_axi_rready,
  input  logic [NUM_ROMS*ROM_WIDTH-1:0] rom_data,
  output logic [ROM_ADDR_BITS-1:0]      rom_addr
);
  localparam logic [31:0] VERSION = 32'h0002_0000;
  localparam logic [31:0] MAGIC   = 32'h5359_4944;
  localparam logic [31:0] CONFIG  = {8'h0, 8'(ROM_LATENCY), 8'(ROM_ADDR_BITS), 8'(NUM_ROMS)};

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb, s_axi_awaddr[15:14],
                       s_axi_awaddr[1:0], s_axi_araddr[15:14], s_axi_araddr[1:0]};

  logic        up_wreq_q, up_wack_q, up_rreq_q, up_rack_q;
  logic [11:0] up_waddr_q, up_raddr_q;
  logic [31:0] up_wdata_q, up_rdata_q;
  logic        wbusy_q, rbusy_q, bvalid_q, rvalid_q;
  logic [31:0] axi_rdata_q;
  logic        aw_hs, ar_hs;

  // AXI4-Lite to up_* bridge: one write and one read outstanding, word addressing
  assign aw_hs         = s_axi_awvalid & s_axi_wvalid & ~wbusy_q;
  assign ar_hs         = s_axi_arvalid & ~rbusy_q;
  assign s_axi_awready = aw_hs;
  assign s_axi_wready  = aw_hs;
  assign s_axi_arready = ~rbusy_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = axi_rdata_q;
  assign s_axi_rresp   = 2'b00;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      up_wreq_q <= 1'b0; up_waddr_q <= '0; up_wdata_q <= '0; wbusy_q <= 1'b0; bvalid_q <= 1'b0;
      up_rreq_q <= 1'b0; up_raddr_q <= '0; rbusy_q <= 1'b0; rvalid_q <= 1'b0; axi_rdata_q <= '0;
    end else begin
      up_wreq_q <= aw_hs;
      up_rreq_q <= ar_hs;
      if (aw_hs) begin
        wbusy_q    <= 1'b1;
        up_waddr_q <= s_axi_awaddr[13:2];
        up_wdata_q <= s_axi_wdata;
      end
      if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
        wbusy_q  <= 1'b0;
      end else if (up_wack_q) begin
        bvalid_q <= 1'b1;
      end
      if (ar_hs) begin
        rbusy_q    <= 1'b1;
        up_raddr_q <= s_axi_araddr[13:2];
      end
      if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
        rbusy_q  <= 1'b0;
      end else if (up_rack_q) begin
        rvalid_q    <= 1'b1;
        axi_rdata_q <= up_rdata_q;
      end
    end
  end

  function automatic logic [31:0] rom_sel(input logic [1:0] ch);
    rom_sel = '0;
    for (int k = 0; k < NUM_ROMS; k++)
      if (ch == 2'(k)) rom_sel = 32'(rom_data[k*ROM_WIDTH +: ROM_WIDTH]);
  endfunction

  logic [31:0] scratch_q;
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      scratch_q <= '0;
      up_wack_q <= 1'b0;
    end else begin
      up_wack_q <= up_wreq_q;
      if (up_wreq_q && up_waddr_q == 12'h002) scratch_q <= up_wdata_q;
    end
  end

  logic [11:0]              rd_hi;
  logic                     rd_in_rom, rom_rreq;
  logic [1:0]               rd_ch, rd_ch_q, rd_cnt_q;
  logic                     rd_busy_q;
  logic [ROM_ADDR_BITS-1:0] rom_addr_q;
  logic                     scan_issue;
  logic [ROM_ADDR_BITS-1:0] scan_rom_addr;
  logic [31:0]              reg_rdata, csum_ctrl, csum_result;

  assign rd_hi     = up_raddr_q >> ROM_ADDR_BITS;
  assign rd_in_rom = (rd_hi != 12'd0) && (rd_hi <= 12'(NUM_ROMS));
  assign rd_ch     = 2'(rd_hi - 12'd1);
  assign rom_rreq  = up_rreq_q & rd_in_rom;
  assign rom_addr  = rom_addr_q;

  // AXI ROM reads own rom_addr; the scan only drives it when no read is pending
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      up_rack_q <= 1'b0; up_rdata_q <= '0; rd_busy_q <= 1'b0;
      rd_cnt_q <= '0; rd_ch_q <= '0; rom_addr_q <= '0;
    end else begin
      up_rack_q  <= 1'b0;
      up_rdata_q <= '0;
      if (rom_rreq) begin
        rd_busy_q  <= 1'b1;
        rd_cnt_q   <= 2'(ROM_LATENCY - 1);
        rd_ch_q    <= rd_ch;
        rom_addr_q <= up_raddr_q[ROM_ADDR_BITS-1:0];
      end else if (up_rreq_q) begin
        up_rack_q  <= 1'b1;
        up_rdata_q <= reg_rdata;
      end else if (rd_busy_q) begin
        if (rd_cnt_q == 2'd0) begin
          rd_busy_q  <= 1'b0;
          up_rack_q  <= 1'b1;
          up_rdata_q <= rom_sel(rd_ch_q);
        end else begin
          rd_cnt_q <= rd_cnt_q - 2'd1;
        end
      end else if (scan_issue) begin
        rom_addr_q <= scan_rom_addr;
      end
    end
  end

`ifdef SYSID_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_ACC, S_DONE} state_t;
  state_t                   state_q;
  logic [ROM_ADDR_BITS-1:0] scan_addr_q;
  logic [31:0]              acc_q, word_q, result_q, acc_d;
  logic [1:0]               wcnt_q, chan_q;
  logic                     done_q, err_q, start_wr, start_bad;

  assign start_wr      = up_wreq_q && up_waddr_q == 12'h005 && up_wdata_q[0];
  assign start_bad     = {1'b0, up_wdata_q[9:8]} >= 3'(NUM_ROMS);
  assign scan_issue    = (state_q == S_ADDR) && !rom_rreq && !rd_busy_q;
  assign scan_rom_addr = scan_addr_q;
  assign acc_d         = acc_q + word_q;
  assign csum_ctrl     = {22'd0, chan_q, 5'd0, err_q, done_q, state_q != S_IDLE};
  assign csum_result   = result_q;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q <= S_IDLE; scan_addr_q <= '0; acc_q <= '0; word_q <= '0; result_q <= '0;
      wcnt_q <= '0; chan_q <= '0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start_wr) begin
          done_q <= 1'b0;
          chan_q <= up_wdata_q[9:8];
          err_q  <= start_bad;
          if (!start_bad) begin
            state_q     <= S_ADDR;
            scan_addr_q <= '0;
            acc_q       <= '0;
          end
        end
        S_ADDR: if (scan_issue) begin
          state_q <= S_WAIT;
          wcnt_q  <= 2'(ROM_LATENCY - 1);
        end
        // a ROM read stealing rom_addr mid-wait invalidates this word; refetch it
        S_WAIT: if (rom_rreq) begin
          state_q <= S_ADDR;
        end else if (wcnt_q == 2'd0) begin
          word_q  <= rom_sel(chan_q);
          state_q <= S_ACC;
        end else begin
          wcnt_q <= wcnt_q - 2'd1;
        end
        S_ACC: begin
          acc_q <= acc_d;
          if (scan_addr_q == '1) begin
            result_q <= acc_d;
            state_q  <= S_DONE;
          end else begin
            scan_addr_q <= scan_addr_q + 1'b1;
            state_q     <= S_ADDR;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`else
  assign scan_issue    = 1'b0;
  assign scan_rom_addr = '0;
  assign csum_ctrl     = '0;
  assign csum_result   = '0;
`endif

  always_comb begin
    reg_rdata = '0;
    case (up_raddr_q)
      12'h000: reg_rdata = VERSION;
      12'h001: reg_rdata = 32'(ID);
      12'h002: reg_rdata = scratch_q;
      12'h003: reg_rdata = MAGIC;
      12'h004: reg_rdata = CONFIG;
      12'h005: reg_rdata = csum_ctrl;
      12'h006: reg_rdata = csum_result;
      default: reg_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_sys_id_multi.sv
// Scoreboard bench for sys_id_multi: reads push expected data, a monitor pops on each AXI R beat.
module tb_sys_id_multi;
  localparam int NR = 2, RW = 16, AB = 6, LAT = 3;
  localparam int WORDS = 1 << AB;
  localparam logic [31:0] IDV = 32'h0000_1234;
  localparam logic [31:0] CFG_EXP = (LAT << 16) | (AB << 8) | NR;

  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;

  logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [15:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;
  logic [NR*RW-1:0] rom_data;
  logic [AB-1:0]    rom_addr;

  sys_id_multi #(.ID(IDV), .NUM_ROMS(NR), .ROM_WIDTH(RW), .ROM_ADDR_BITS(AB), .ROM_LATENCY(LAT)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn),
    .s_axi_awvalid(awvalid), .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awready(awready),
    .s_axi_wvalid(wvalid), .s_axi_wdata(wdata), .s_axi_wstrb(4'hF), .s_axi_wready(wready),
    .s_axi_bvalid(bvalid), .s_axi_bresp(bresp), .s_axi_bready(bready),
    .s_axi_arvalid(arvalid), .s_axi_araddr(araddr), .s_axi_arprot(3'b000), .s_axi_arready(arready),
    .s_axi_rvalid(rvalid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rready(rready),
    .rom_data(rom_data), .rom_addr(rom_addr));

  // ROM model: data for an address is visible LAT clocks after rom_addr changes
  logic [RW-1:0] mem [NR][WORDS];
  logic [AB-1:0] a1, a2;
  always @(posedge clk) begin a1 <= rom_addr; a2 <= a1; end
  always_comb begin
    rom_data = '0;
    for (int k = 0; k < NR; k++) rom_data[k*RW +: RW] = mem[k][a2];
  end

  typedef struct { logic [31:0] exp; logic [31:0] mask; bit chk; string name; } sb_t;
  sb_t sbq[$];
  sb_t me;
  int vecs = 0, errs = 0, rv_cnt = 0, lat_cnt = 0, last_lat = -1;
  bit lat_on = 0;
  logic [31:0] last_rdata = '0, scratch_m = '0;

  always @(negedge clk) begin
    if (rstn && rvalid && rready) begin
      rv_cnt++;
      if (sbq.size() == 0) begin
        vecs++; errs++;
        $display("FAIL unexpected_rdata: got %08h with nothing outstanding", rdata);
      end else begin
        me = sbq.pop_front();
        last_rdata = rdata;
        if (me.chk) begin
          vecs++;
          if ((rdata & me.mask) !== (me.exp & me.mask)) begin
            errs++;
            $display("FAIL %s: got %08h required %08h (mask %08h)", me.name, rdata, me.exp, me.mask);
          end
        end
      end
    end
    if (rstn && !dut.up_rack_q && dut.up_rdata_q != 32'd0) begin
      vecs++; errs++;
      $display("FAIL rdata_idle: up_rdata %08h while rack low, required 0", dut.up_rdata_q);
    end
    if (dut.up_rreq_q) begin lat_on = 1; lat_cnt = 0; end
    else if (lat_on) begin
      lat_cnt++;
      if (dut.up_rack_q) begin lat_on = 0; last_lat = lat_cnt; end
    end
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin errs++; $display("FAIL %s: got %08h required %08h", nm, act, exp); end
  endtask

  task automatic axi_read(input logic [11:0] a, input logic [31:0] exp, input logic [31:0] mask,
                          input bit chk, input string nm);
    int t;
    sb_t e;
    e.exp = exp; e.mask = mask; e.chk = chk; e.name = nm;
    sbq.push_back(e);
    @(posedge clk); #1;
    arvalid = 1'b1; araddr = {2'b00, a, 2'b00};
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 100);
    if (!arready) begin
      vecs++; errs++;
      $display("FAIL ar_handshake %s: arready 0, required 1", nm);
      void'(sbq.pop_back());
      arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sbq.size() != 0 && t < 300) begin @(negedge clk); t++; end
    if (sbq.size() != 0) begin
      vecs++; errs++;
      $display("FAIL read_timeout: %0d outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
    int t;
    wait_drain();
    @(posedge clk); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = {2'b00, a, 2'b00}; wdata = d;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 100);
    @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!bvalid && t < 100);
    vecs++;
    if (!bvalid || bresp != 2'b00) begin
      errs++;
      $display("FAIL write_resp @%03h: bvalid %0b bresp %0d, required 1/0", a, bvalid, bresp);
    end
  endtask

  task automatic read_val(input logic [11:0] a, output logic [31:0] v);
    axi_read(a, '0, '0, 1'b0, "raw");
    wait_drain();
    v = last_rdata;
  endtask

  task automatic poll_done(output logic [31:0] st);
    int n = 0;
    st = 32'h1;
    while (st[0] && n < 400) begin read_val(12'h005, st); n++; end
    if (st[0]) begin vecs++; errs++; $display("FAIL scan_timeout: busy 1, required 0"); end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sbq.delete();
    awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (2) @(negedge clk);
    chk32("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk32("reset_rvalid", 32'(rvalid), 32'd0);
    chk32("reset_bvalid", 32'(bvalid), 32'd0);
    rstn = 1'b1;
    scratch_m = '0;
  endtask

  function automatic logic [31:0] rom_sum(input int k);
    logic [31:0] s = 0;
    for (int n = 0; n < WORDS; n++) s += 32'(mem[k][n]);
    return s;
  endfunction

  function automatic logic [11:0] rom_wa(input int k, input int n);
    return 12'(((k + 1) * WORDS) + n);
  endfunction

  function automatic logic [31:0] reg_model(input int a);
    case (a)
      0: return 32'h0002_0000;
      1: return IDV;
      2: return scratch_m;
      3: return 32'h5359_4944;
      default: return CFG_EXP;
    endcase
  endfunction

  task automatic randomize_mem();
    for (int k = 0; k < NR; k++)
      for (int n = 0; n < WORDS; n++) mem[k][n] = RW'($urandom);
  endtask

  initial begin
    logic [31:0] st, v, d;
    int k, n, op, rc;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    awaddr = '0; araddr = '0; wdata = '0;
    for (int i = 0; i < WORDS; i++) begin
      mem[0][i] = RW'(i);
      mem[1][i] = RW'(i + 32'h100);
    end
    do_reset();
    @(negedge clk);

    axi_read(12'h000, 32'h0002_0000, '1, 1, "version");
    axi_read(12'h001, IDV, '1, 1, "id");
    axi_read(12'h003, 32'h5359_4944, '1, 1, "magic");
    axi_read(12'h004, CFG_EXP, '1, 1, "config");
    wait_drain();
    chk32("reg_rack_latency", 32'(last_lat), 32'd1);

    axi_write(12'h002, 32'hA5A5_0001); scratch_m = 32'hA5A5_0001;
    axi_read(12'h002, scratch_m, '1, 1, "scratch");
    axi_read(12'h085, 32'h0000_0105, '1, 1, "rom1_word5");
    wait_drain();
    chk32("rom_rack_latency", 32'(last_lat), 32'(LAT + 1));
    axi_read(12'h007, '0, '1, 1, "unmapped_07");
    axi_read(rom_wa(NR, 0), '0, '1, 1, "unmapped_above_roms");
    axi_write(rom_wa(NR, 3), 32'hDEAD_BEEF);
    axi_read(12'h002, scratch_m, '1, 1, "scratch_after_unmapped_wr");
    wait_drain();
    do_reset();
    axi_read(12'h002, '0, '1, 1, "scratch_after_reset");

`ifdef SYSID_CHECKSUM_EN
    axi_write(12'h005, 32'h001);
    axi_read(12'h005, 32'h001, 32'h307, 1, "csum_busy");
    poll_done(st);
    chk32("csum_done_ctrl", st, 32'h002);
    axi_read(12'h006, 32'h0000_07E0, '1, 1, "csum_rom0");

    axi_write(12'h005, 32'h301);
    axi_read(12'h005, 32'h304, '1, 1, "csum_bad_channel");
    axi_read(12'h006, 32'h0000_07E0, '1, 1, "csum_hold_after_err");

    axi_write(12'h005, 32'h001);
    repeat (30) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, WORDS - 1);
      axi_read(rom_wa(0, n), 32'(mem[0][n]), '1, 1, "rom0_mid_scan");
    end
    poll_done(st);
    chk32("csum_interrupted_ctrl", st, 32'h002);
    axi_read(12'h006, 32'h0000_07E0, '1, 1, "csum_interrupted");

    randomize_mem();
    axi_write(12'h005, 32'h101);
    axi_write(12'h005, 32'h001);
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, NR - 1); n = $urandom_range(0, WORDS - 1);
      axi_read(rom_wa(k, n), 32'(mem[k][n]), '1, 1, "rom_rand_mid_scan");
    end
    poll_done(st);
    chk32("csum_busy_start_ignored", st, 32'h102);
    axi_read(12'h006, rom_sum(1), '1, 1, "csum_rom1_random");
    wait_drain();

    axi_write(12'h005, 32'h001);
    repeat (40) @(posedge clk);
    axi_read(rom_wa(0, 7), '0, '0, 0, "aborted");
    repeat (2) @(posedge clk);
    rc = rv_cnt;
    do_reset();
    repeat (30) @(negedge clk);
    chk32("no_residual_rack", 32'(rv_cnt), 32'(rc));
    axi_read(12'h005, '0, '1, 1, "ctrl_after_reset");
    axi_read(12'h006, '0, '1, 1, "result_after_reset");
`else
    axi_write(12'h005, 32'h001);
    axi_read(12'h005, '0, '1, 1, "ctrl_disabled");
    axi_write(12'h006, 32'h1234_5678);
    axi_read(12'h006, '0, '1, 1, "result_disabled");
    axi_read(rom_wa(1, 9), 32'(mem[1][9]), '1, 1, "rom1_word9");
    wait_drain();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk32("rom_addr_read_only", 32'(rom_addr), 32'd9);
    axi_read(rom_wa(0, 7), '0, '0, 0, "aborted");
    repeat (2) @(posedge clk);
    rc = rv_cnt;
    do_reset();
    repeat (30) @(negedge clk);
    chk32("no_residual_rack", 32'(rv_cnt), 32'(rc));
    randomize_mem();
`endif

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 4);
      case (op)
        0: begin n = $urandom_range(0, 4); axi_read(12'(n), reg_model(n), '1, 1, "rand_reg"); end
        1: begin
          k = $urandom_range(0, NR - 1); n = $urandom_range(0, WORDS - 1);
          axi_read(rom_wa(k, n), 32'(mem[k][n]), '1, 1, "rand_rom");
        end
        2: begin d = $urandom; axi_write(12'h002, d); scratch_m = d; end
        3: axi_read(12'($urandom_range(rom_wa(NR, 0), 12'hFFF)), '0, '1, 1, "rand_unmapped");
        default: axi_write(12'($urandom_range(rom_wa(NR, 0), 12'hFFF)), $urandom);
      endcase
    end
    axi_read(12'h002, scratch_m, '1, 1, "scratch_final");
    wait_drain();
    read_val(12'h001, v);
    chk32("id_final", v, IDV);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
